// File: rtl/sm_als_pkg.sv
// Shared frame geometry and frame-word builder for the ALS SPI slave model.
package sm_als_pkg;

    localparam int unsigned ALS_LEAD_ZEROS = 3;
    localparam int unsigned ALS_DATA_W     = 8;
    localparam int unsigned ALS_TAIL_ZEROS = 5;
    localparam int unsigned ALS_FRAME_BITS = ALS_LEAD_ZEROS + ALS_DATA_W + ALS_TAIL_ZEROS;

    typedef logic [ALS_FRAME_BITS-1:0] als_frame_t;
    typedef logic [ALS_DATA_W-1:0]     als_data_t;

    function automatic als_frame_t als_build_frame(input als_data_t value);
        return {{ALS_LEAD_ZEROS{1'b0}}, value, {ALS_TAIL_ZEROS{1'b0}}};
    endfunction

endpackage

// File: rtl/sm_sync_edge.sv
// Two-flop synchroniser with a third delay flop producing single-cycle rise/fall pulses.
module sm_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/sm_als_sensor.sv
// PmodALS-style SPI slave model: shifts out {3'b0, light, 5'b0} MSB first on
// oversampled sck falls and advances the light value after every complete frame.
module sm_als_sensor
    import sm_als_pkg::*;
#(
    parameter logic [7:0]  LIGHT_INIT = 8'hA5,
    parameter logic [7:0]  LIGHT_STEP = 8'h01,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       sck,
    output logic       sdo,
    output logic [7:0] light_value,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic cs_lvl;
    logic cs_rise;
    logic cs_fall;
    logic sck_fall;
    logic sck_level_unused;
    logic sck_rise_unused;

    sm_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sm_sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_level_unused),
        .rise  (sck_rise_unused),
        .fall  (sck_fall)
    );

    als_frame_t       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       light_q, light_d;
    logic             frame_done_q, frame_done_d;
    logic             sdo_q, sdo_d;

    // cs edges outrank sck; a coincident sck fall is dropped.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        light_d      = light_q;
        frame_done_d = 1'b0;
        if (cs_rise) begin
            if (cnt_q == CNT_FULL) begin
                light_d      = light_q + LIGHT_STEP;
                frame_done_d = 1'b1;
            end
            cnt_d   = '0;
            shift_d = '0;
        end else if (cs_fall) begin
            shift_d = als_build_frame(light_q);
            cnt_d   = '0;
        end else if (!cs_lvl && sck_fall) begin
            shift_d = {shift_q[ALS_FRAME_BITS-2:0], 1'b0};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        sdo_d = cs_lvl ? 1'b0 : shift_d[ALS_FRAME_BITS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            light_q      <= LIGHT_INIT;
            frame_done_q <= 1'b0;
            sdo_q        <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            light_q      <= light_d;
            frame_done_q <= frame_done_d;
            sdo_q        <= sdo_d;
        end
    end

    assign sdo         = sdo_q;
    assign light_value = light_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sm_als_sensor.sv
// Scoreboard bench for sm_als_sensor: two instances (default and LIGHT_INIT=8'hFF) share sck.
module tb_sm_als_sensor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic       cs_b = 1'b1;
    logic       sck = 1'b1;
    logic       sdo_a, sdo_b;
    logic [7:0] light_a, light_b;
    logic       fd_a, fd_b;

    always #5 clk = ~clk;

    sm_als_sensor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .sck         (sck),
        .sdo         (sdo_a),
        .light_value (light_a),
        .frame_done  (fd_a)
    );

    sm_als_sensor #(.LIGHT_INIT(8'hFF)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs_b),
        .sck         (sck),
        .sdo         (sdo_b),
        .light_value (light_b),
        .frame_done  (fd_b)
    );

    typedef struct {
        logic [15:0] word;
        int          nbits;
        bit          skip;
    } frame_exp_t;

    frame_exp_t word_q[$];
    logic [7:0] light_exp_a[$];
    logic [7:0] light_exp_b[$];

    int n_vec = 0;
    int n_miss = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Master-side capture: bit k is on sdo just before the k-th sck fall.
    logic [15:0] cap_word = '0;
    int          cap_n = 0;
    logic        cap_extra = 1'b0;
    wire         cs_any = cs & cs_b;

    always @(negedge sck) begin : sampler
        logic b;
        if (mon_en) begin
            if (!cs_any) begin
                if (!cs) begin
                    b = sdo_a;
                    check("idle_sdo_b", sdo_b, 0);
                end else begin
                    b = sdo_b;
                    check("idle_sdo_a", sdo_a, 0);
                end
                if (cap_n < 16) cap_word[15-cap_n] = b;
                else cap_extra = cap_extra | b;
                cap_n++;
            end else begin
                check("cs_high_sdo_a", sdo_a, 0);
                check("cs_high_sdo_b", sdo_b, 0);
            end
        end
    end

    always @(posedge cs_any) begin : word_checker
        frame_exp_t  e;
        logic [15:0] m;
        if (mon_en) begin
            check("word_q_nonempty", 32'(word_q.size() != 0), 1);
            if (word_q.size() != 0) begin
                e = word_q.pop_front();
                check("frame_bit_count", cap_n, e.nbits);
                if (!e.skip) begin
                    m = (e.nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> e.nbits);
                    check("frame_word", cap_word, e.word & m);
                    if (e.nbits > 16) check("tail_bits_zero", cap_extra, 0);
                end
            end
            cap_word  = '0;
            cap_n     = 0;
            cap_extra = 1'b0;
        end
    end

    logic fd_a_prev = 1'b0;
    logic fd_b_prev = 1'b0;

    always @(negedge clk) begin : done_monitor
        if (mon_en) begin
            if (fd_a) begin
                pulses_a++;
                check("frame_done_a_width", fd_a_prev, 0);
                check("light_exp_a_nonempty", 32'(light_exp_a.size() != 0), 1);
                if (light_exp_a.size() != 0) check("light_a_update", light_a, light_exp_a.pop_front());
            end
            if (fd_b) begin
                pulses_b++;
                check("frame_done_b_width", fd_b_prev, 0);
                check("light_exp_b_nonempty", 32'(light_exp_b.size() != 0), 1);
                if (light_exp_b.size() != 0) check("light_b_update", light_b, light_exp_b.pop_front());
            end
        end
        fd_a_prev = fd_a;
        fd_b_prev = fd_b;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b0;
            wait_clk(8);
            sck = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic run_frame(input bit use_b, input int nfalls, input logic [15:0] word,
                             input logic [7:0] light_after);
        word_q.push_back('{word: word, nbits: nfalls, skip: 1'b0});
        if (nfalls >= 16) begin
            if (use_b) light_exp_b.push_back(light_after);
            else light_exp_a.push_back(light_after);
        end
        wait_clk(1);
        if (use_b) cs_b = 1'b0;
        else cs = 1'b0;
        wait_clk(8);
        sck_pulses(nfalls);
        if (use_b) cs_b = 1'b1;
        else cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic pulse_reset();
        wait_clk(1);
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        wait_clk(2);
        #1;
        check("reset_sdo_a", sdo_a, 0);
        check("reset_light_a", light_a, 8'hA5);
        check("reset_frame_done_a", fd_a, 0);
        check("reset_light_b", light_b, 8'hFF);
        rst_n = 1'b1;
        wait_clk(4);
        mon_en = 1'b1;

        run_frame(1'b0, 16, 16'h14A0, 8'hA6);
        run_frame(1'b0, 16, 16'h14C0, 8'hA7);
        check("light_a_after_two", light_a, 8'hA7);

        run_frame(1'b1, 16, 16'h1FE0, 8'h00);
        check("light_b_wrap", light_b, 8'h00);

        pulse_reset();
        check("light_a_after_reset", light_a, 8'hA5);
        run_frame(1'b0, 10, 16'h14A0, 8'hA5);
        check("light_a_short_frame", light_a, 8'hA5);
        run_frame(1'b0, 16, 16'h14A0, 8'hA6);

        sck_pulses(5);
        check("light_a_sck_cs_high", light_a, 8'hA6);
        run_frame(1'b0, 20, 16'h14C0, 8'hA7);
        check("light_a_long_frame", light_a, 8'hA7);

        // Frame aborted by reset after 6 falls; its captured bits are not word-checked.
        word_q.push_back('{word: 16'h0000, nbits: 6, skip: 1'b1});
        wait_clk(1);
        cs = 1'b0;
        wait_clk(8);
        sck_pulses(6);
        rst_n = 1'b0;
        #1;
        check("abort_sdo_a", sdo_a, 0);
        check("abort_light_a", light_a, 8'hA5);
        check("abort_light_b", light_b, 8'hFF);
        check("abort_frame_done_a", fd_a, 0);
        wait_clk(2);
        cs = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(8);
        run_frame(1'b0, 16, 16'h14A0, 8'hA6);

        wait_clk(20);
        check("pulse_count_a", pulses_a, 5);
        check("pulse_count_b", pulses_b, 1);
        check("word_q_drained", word_q.size(), 0);
        check("light_q_a_drained", light_exp_a.size(), 0);
        check("light_q_b_drained", light_exp_b.size(), 0);
        check("final_light_a", light_a, 8'hA6);
        check("final_light_b", light_b, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
